// File: rtl/div_unit_seq_pkg.sv
// Shared definitions for the sequential divider: op encoding, FSM states
// and small decode helpers used by the datapath.
package div_unit_seq_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    // Signed variants are the ones with op[0] clear (DIV, REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Remainder variants are the ones with op[1] set (REM, REMU).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_seq_if.sv
// Request/response bundle of the sequential divider.
interface div_unit_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-compare-subtract iteration of unsigned long division.
// The partial remainder carries one spare bit so the shifted value never
// overflows; the subtraction is done one bit wider again so its top bit is
// a clean borrow flag.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {2'b00, divisor};
    // No borrow means the divisor fits: keep the difference, emit a 1.
    assign q_bit    = ~diff[WIDTH+1];
    assign rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/div_unit_seq.sv
// Sequential radix-2 restoring divider. Signed operations are reduced to
// unsigned magnitudes at start and sign-corrected in the FIX state, so the
// iterating core only ever sees unsigned values.
module div_unit_seq
    import div_unit_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    div_unit_seq_if.slave bus
);
    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Operand/working registers: quo starts as the dividend magnitude and
    // fills with quotient bits from the right as dividend bits leave the top.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH:0]   rem;
    logic             is_rem;
    logic             neg_q;
    logic             neg_r;
    logic             zero_div;

    logic             accept;
    logic             b_zero;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_result;

    // Two's-complement negate when neg is set; used both to take operand
    // magnitudes and to restore result signs. The most negative value maps
    // onto itself, which yields the required overflow quotient for free.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? ('0 - v) : v;
    endfunction

    assign accept = (state == IDLE) && bus.start;
    assign b_zero = (bus.b == '0);
    assign sign_a = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign sign_b = op_is_signed(bus.op) & bus.b[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (dvsr),
        .bit_in   (quo[WIDTH-1]),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Divide-by-zero bypasses the sign fix: all-ones quotient, raw dividend
    // as remainder.
    assign q_fix      = zero_div ? '1    : apply_sign(quo, neg_q);
    assign r_fix      = zero_div ? a_raw : apply_sign(rem[WIDTH-1:0], neg_r);
    assign fix_result = is_rem ? r_fix : q_fix;

    // Datapath: latch operands on acceptance, then one iteration per CALC edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            quo      <= apply_sign(bus.a, sign_a);
            dvsr     <= apply_sign(bus.b, sign_b);
            rem      <= '0;
            a_raw    <= bus.a;
            is_rem   <= op_is_rem(bus.op);
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            zero_div <= b_zero;
        end else if (state == CALC) begin
            quo <= {quo[WIDTH-2:0], step_q};
            rem <= step_rem;
        end
    end

    // Control FSM with registered busy/done/result/div_by_zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= b_zero ? FIX : CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state           <= IDLE;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                    bus.result      <= fix_result;
                    bus.div_by_zero <= zero_div;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit_seq.sv
// Bench for div_unit_seq (WIDTH=32): directed corner cases plus a random
// stream, with expected responses queued at issue time and checked by an
// independent monitor whenever done is seen.
module tb_div_unit_seq;
    import div_unit_seq_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           acc;
        int           lat;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    div_unit_seq_if #(.WIDTH(W)) bus ();

    div_unit_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference: plain arithmetic with the divide-by-zero and overflow rules.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
        logic [W-1:0] r;
        logic         z;
        z = (y == '0);
        if (z) begin
            r = o[1] ? x : '1;
        end else if (!o[0]) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                r = o[1] ? '0 : x;
            else
                r = o[1] ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
        end else begin
            r = o[1] ? (x % y) : (x / y);
        end
        return {z, r};
    endfunction

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now(name);
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now(name);
    endtask

    // Called at a negedge; drives a one-cycle start and queues the expectation.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ez, input bit idle_first,
                         input string tag);
        exp_t e;
        if (idle_first) wait_idle({tag, ".idle"});
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        e.res = er;
        e.dbz = ez;
        e.acc = cyc;
        e.lat = (y == '0) ? 1 : W + 1;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               input string tag);
        logic [W:0] m;
        m = model(o, x, y);
        issue(o, x, y, m[W-1:0], m[W], 1'b1, tag);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: result 0x%0h, none queued", bus.result);
            end else begin
                e = sb.pop_front();
                check({e.tag, ".result"}, 64'(bus.result), 64'(e.res));
                check({e.tag, ".div_by_zero"}, 64'(bus.div_by_zero), 64'(e.dbz));
                check({e.tag, ".latency"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           k;
        bit           ok;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_DIVU;
        bus.a     = '0;
        bus.b     = '0;
        #1 reset = 1'b0;
        #1;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.result", 64'(bus.result), 64'd0);
        check("reset.div_by_zero", 64'(bus.div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, "divu_100_7");
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1, "remu_100_7");
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1, "div_m7_2");
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1, "rem_m7_2");
        issue(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, "divu_5_0");
        issue(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1'b1, "remu_5_0");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, "div_ovf");
        issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, "rem_ovf");

        // A start while busy must not disturb the running op; a start held in
        // the done cycle must be taken immediately.
        issue(OP_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b1, "divu_busy_start");
        repeat (9) @(negedge clk);
        bus.op    = OP_DIVU;
        bus.a     = 32'd77;
        bus.b     = 32'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_start.done");
        issue(OP_DIVU, 32'd50, 32'd5, 32'd10, 1'b0, 1'b0, "divu_back_to_back");

        // Reset in the middle of CALC aborts without a done pulse.
        issue(OP_DIVU, 32'd12345, 32'd7, 32'd1763, 1'b0, 1'b1, "divu_aborted");
        repeat (15) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midcalc_reset.busy", 64'(bus.busy), 64'd0);
        check("midcalc_reset.done", 64'(bus.done), 64'd0);
        check("midcalc_reset.result", 64'(bus.result), 64'd0);
        check("midcalc_reset.div_by_zero", 64'(bus.div_by_zero), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1, "divu_9_3_after_reset");

        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            k = $urandom_range(0, 9);
            case (k)
                0:       y = '0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2:       y = 32'($urandom_range(1, 15));
                3:       y = '0 - 32'($urandom_range(1, 15));
                4:       y = x >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            issue_model(o, x, y, "rand");
        end

        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("drain");
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
